// File: rtl/sr_drv_pkg.sv
// Shared types and helpers for the sr_latch_driver block.
//   sr_drv_state_t : driver FSM states
//   cnt_width()    : bit width needed for the dwell counter
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GAP_PRE  = 2'd1,
    PULSE    = 2'd2,
    GAP_POST = 2'd3
  } sr_drv_state_t;

  // The counter holds at most max(a, b) - 1, so this width always has headroom.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// Loadable down-counter that times the dwell in each driver state.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load `value` into the counter this edge
//   value      : reload value (state length minus one)
//   zero       : counter has reached zero (last cycle of the current state)
module sr_drv_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Drives a level-sensitive sr_latch from a valid/ready request carrying a
// target level. Each write is a PULSE_CYC-cycle en+s or en+r pulse framed by
// GAP_CYC all-low cycles on both sides; s and r are never high together.
// A shadow copy of the last written level lets redundant writes be skipped
// unless req_force is set.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 exactly when the FSM is in IDLE.
// req_val/req_force are captured on that edge.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake
//   req_val, req_force    : target level, pulse even if shadow matches
//   s, r, en              : registered latch controls
//   q_in, qbar_in         : latch readback
//   done                  : one-cycle completion strobe (pulsed or skipped)
//   busy                  : FSM not in IDLE
//   shadow_q, shadow_vld  : last written level and its validity
//   err                   : sticky readback error
//
// Build option: define SR_LATCH_DRIVER_READBACK_EN to check q_in/qbar_in on
// the last pulse cycle; otherwise err is tied low and the readback is unused.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_val,
  input  logic req_force,
  output logic s,
  output logic r,
  output logic en,
  input  logic q_in,
  input  logic qbar_in,
  output logic done,
  output logic busy,
  output logic shadow_q,
  output logic shadow_vld,
  output logic err
);

  localparam int CW = cnt_width(PULSE_CYC, GAP_CYC);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);

  sr_drv_state_t r_state;
  sr_drv_state_t w_next;

  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_zero;
  logic          w_accept;
  logic          w_pulse_req;
  logic          w_skip;
  logic          w_fin;
  logic          r_cap;
  logic          r_s;
  logic          r_r;
  logic          r_en;
  logic          r_done;
  logic          r_shadow_q;
  logic          r_shadow_vld;

  sr_drv_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .value (w_load_val),
    .zero  (w_zero)
  );

  assign req_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign w_accept    = req_valid & req_ready;
  assign w_pulse_req = req_force | ~r_shadow_vld | (req_val != r_shadow_q);

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = GAP_LD;
    w_skip     = 1'b0;
    w_fin      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_pulse_req) begin
            w_next     = GAP_PRE;
            w_load     = 1'b1;
            w_load_val = GAP_LD;
          end else begin
            w_skip = 1'b1;
          end
        end
      end
      GAP_PRE: begin
        if (w_zero) begin
          w_next     = PULSE;
          w_load     = 1'b1;
          w_load_val = PULSE_LD;
        end
      end
      PULSE: begin
        if (w_zero) begin
          w_next     = GAP_POST;
          w_load     = 1'b1;
          w_load_val = GAP_LD;
        end
      end
      GAP_POST: begin
        if (w_zero) begin
          w_next = IDLE;
          w_fin  = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Latch controls are decoded from the next state so they line up with the
  // PULSE state cycle-for-cycle. r_cap is never written on an edge that
  // enters PULSE (it is written only when leaving IDLE), so it is stable here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cap        <= 1'b0;
      r_s          <= 1'b0;
      r_r          <= 1'b0;
      r_en         <= 1'b0;
      r_done       <= 1'b0;
      r_shadow_q   <= 1'b0;
      r_shadow_vld <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept && w_pulse_req) begin
        r_cap <= req_val;
      end
      r_en   <= (w_next == PULSE);
      r_s    <= (w_next == PULSE) &  r_cap;
      r_r    <= (w_next == PULSE) & ~r_cap;
      r_done <= w_skip | w_fin;
      if (r_state == PULSE && w_next == GAP_POST) begin
        r_shadow_q   <= r_cap;
        r_shadow_vld <= 1'b1;
      end
    end
  end

  assign s          = r_s;
  assign r          = r_r;
  assign en         = r_en;
  assign done       = r_done;
  assign shadow_q   = r_shadow_q;
  assign shadow_vld = r_shadow_vld;

`ifdef SR_LATCH_DRIVER_READBACK_EN
  logic r_err;

  // By the last pulse cycle the latch has had PULSE_CYC-1 cycles to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (r_state == PULSE && w_zero &&
                 ((q_in != r_cap) || (q_in == qbar_in))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_rb;
  assign w_unused_rb = q_in ^ qbar_in;
  assign err         = 1'b0;
`endif

  a_no_forbidden: assert property (@(posedge clk) !(s && r));
  a_sr_needs_en:  assert property (@(posedge clk) (s || r) |-> en);

endmodule

// File: tb/tb_sr_latch_driver.sv
module tb_sr_latch_driver;

  localparam int P   = 4;
  localparam int G   = 2;
  localparam int TOT = 2 * G + P;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_val = 1'b0;
  logic req_force = 1'b0;
  logic req_ready, s, r, en, done, busy, shadow_q, shadow_vld, err;
  logic q_in, qbar_in;

  // behavioural latch plus readback fault injection
  logic lq = 1'b0;
  logic inj_q0 = 1'b0;
  always @(s or r or en) begin
    if (en && s) lq = 1'b1;
    else if (en && r) lq = 1'b0;
  end
  assign q_in    = inj_q0 ? 1'b0 : lq;
  assign qbar_in = ~lq;

  sr_latch_driver #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_val    (req_val),
    .req_force  (req_force),
    .s          (s),
    .r          (r),
    .en         (en),
    .q_in       (q_in),
    .qbar_in    (qbar_in),
    .done       (done),
    .busy       (busy),
    .shadow_q   (shadow_q),
    .shadow_vld (shadow_vld),
    .err        (err)
  );

  // clock
  always #5 clk = ~clk;

  // counters and checker
  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // transaction-level model: remembers the accepted request and derives
  // every output from the cycle offset since acceptance
  int e = 0;
  int t_acc = 0;
  int dp;
  bit m_act = 0, m_pulse = 0, m_val = 0, m_inj = 0;
  bit m_sh_q = 0, m_sh_vld = 0, m_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_sh_q = 0; m_sh_vld = 0; m_err = 0;
    end else begin
      e  = e + 1;
      dp = e - 1 - t_acc;
      if (req_valid && !(m_act && m_pulse && dp < TOT)) begin
        if (m_act && m_pulse) begin
          m_sh_q = m_val; m_sh_vld = 1;
          if (m_inj && m_val) m_err = 1;
        end
        m_pulse = req_force || !m_sh_vld || (req_val != m_sh_q);
        m_val   = req_val;
        m_inj   = inj_q0;
        t_acc   = e;
        m_act   = 1;
      end
    end
  end

  // compare process, every cycle on the falling edge
  int d;
  bit in_p, x_busy, x_en, x_done, upd, x_err;
  always @(negedge clk) begin
    d      = e - t_acc;
    in_p   = m_act && m_pulse;
    x_busy = in_p && d < TOT;
    x_en   = in_p && d >= G && d < G + P;
    x_done = m_act && (m_pulse ? (d == TOT) : (d == 0));
    upd    = in_p && d >= G + P;
`ifdef SR_LATCH_DRIVER_READBACK_EN
    x_err  = m_err || (upd && m_inj && m_val);
`else
    x_err  = 0;
`endif
    chk("cyc_en",     en,        x_en);
    chk("cyc_s",      s,         x_en && m_val);
    chk("cyc_r",      r,         x_en && !m_val);
    chk("cyc_done",   done,      x_done);
    chk("cyc_busy",   busy,      x_busy);
    chk("cyc_ready",  req_ready, !x_busy);
    chk("cyc_shq",    shadow_q,  upd ? m_val : m_sh_q);
    chk("cyc_shv",    shadow_vld, upd ? 1 : m_sh_vld);
    chk("cyc_err",    err,       x_err);
    chk("cyc_sr_excl", s && r,   0);
  end

  // driver: one request, then wait for done; compares latency with exp_q
  int en_cnt, s_cnt, r_cnt;
  task automatic do_req(input logic v, input logic f);
    int lat;
    logic [7:0] xl;
    for (int i = 0; i < 40 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("ready_wait", req_ready, 1);
    req_valid = 1'b1; req_val = v; req_force = f;
    @(posedge clk); #1;
    req_valid = 1'b0; req_force = 1'b0;
    lat = 0; en_cnt = 0; s_cnt = 0; r_cnt = 0;
    while (lat < 40) begin
      lat++;
      en_cnt += int'(en); s_cnt += int'(s); r_cnt += int'(r);
      if (done) break;
      @(posedge clk); #1;
    end
    xl = exp_q.pop_front();
    chk("latency", lat, int'(xl));
  endtask

  logic [2:0] tbl[7];
  initial begin
    // {val, force, pulsed}
    tbl[0] = 3'b101; tbl[1] = 3'b100; tbl[2] = 3'b001; tbl[3] = 3'b011;
    tbl[4] = 3'b111; tbl[5] = 3'b001; tbl[6] = 3'b000;

    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s", s, 0); chk("rst_r", r, 0); chk("rst_en", en, 0);
    chk("rst_done", done, 0); chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1); chk("rst_shq", shadow_q, 0);
    chk("rst_shv", shadow_vld, 0); chk("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // first set write
    exp_q.push_back(8'd9);
    do_req(1'b1, 1'b0);
    chk("set_en_cycles", en_cnt, 4); chk("set_s_cycles", s_cnt, 4);
    chk("set_r_cycles", r_cnt, 0);
    chk("set_shq", shadow_q, 1); chk("set_shv", shadow_vld, 1);
    chk("set_latch", lq, 1);

    // redundant write is skipped
    exp_q.push_back(8'd1);
    do_req(1'b1, 1'b0);
    chk("skip_en_cycles", en_cnt, 0);

    // forced rewrite, then back-to-back reset write in the done cycle
    exp_q.push_back(8'd9);
    do_req(1'b1, 1'b1);
    chk("force_s_cycles", s_cnt, 4);
    exp_q.push_back(8'd9);
    do_req(1'b0, 1'b0);
    chk("clr_r_cycles", r_cnt, 4); chk("clr_s_cycles", s_cnt, 0);
    chk("clr_latch", lq, 0); chk("clr_shq", shadow_q, 0);

    // reset during PULSE
    req_valid = 1'b1; req_val = 1'b0; req_force = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_force = 1'b0;
    for (int i = 0; i < 20 && !en; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_saw_en", en, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("abort_en", en, 0); chk("abort_r", r, 0); chk("abort_s", s, 0);
    chk("abort_shv", shadow_vld, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // shadow invalid: a write matching the reset shadow value still pulses
    exp_q.push_back(8'd9);
    do_req(1'b0, 1'b0);
    chk("post_abort_r_cycles", r_cnt, 4);

    // directed vector table, back-to-back
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(tbl[i][0] ? 8'd9 : 8'd1);
      do_req(tbl[i][2], tbl[i][1]);
      chk("tbl_en_cycles", en_cnt, tbl[i][0] ? 4 : 0);
    end

    // readback fault during a set pulse
    inj_q0 = 1'b1;
    exp_q.push_back(8'd9);
    do_req(1'b1, 1'b1);
    inj_q0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
`ifdef SR_LATCH_DRIVER_READBACK_EN
    chk("rb_err_sticky", err, 1);
`else
    chk("rb_err_off", err, 0);
`endif
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rb_err_cleared", err, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Synchronous driver for the level-sensitive `sr_latch` that converts a valid/ready request carrying a target level into a safe set or reset pulse on the latch's `s`/`r`/`en` inputs. It guarantees `s` and `r` are never high together (the latch's forbidden state). It enforces dead time around every pulse and keeps a shadow copy of the latch state so redundant writes are skipped. It sits between control logic on the `clk` domain and any `sr_latch` instance.

## Interface
- `PULSE_CYC`, default 4: cycles `en` and `s`/`r` are held high per write. Legal range ≥1.
- `GAP_CYC`, default 2: all-low dead-time cycles before and after each pulse. Legal range ≥1.
- `clk`  input  1: rising-edge clock.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `req_valid`  input  1: write request present.
- `req_ready`  output  1: driver can accept a request.
- `req_val`  input  1: target latch level (1 = set, 0 = reset).
- `req_force`  input  1: pulse even when the shadow already equals `req_val`.
- `s`  output  1: to latch `s`.
- `r`  output  1: to latch `r`.
- `en`  output  1: to latch `en`.
- `q_in`  input  1: latch `q` readback.
- `qbar_in`  input  1: latch `qbar` readback.
- `done`  output  1: one-cycle completion strobe.
- `busy`  output  1: high in any state other than IDLE.
- `shadow_q`  output  1: last level written.
- `shadow_vld`  output  1: `shadow_q` is meaningful.
- `err`  output  1: sticky readback error.

## Operation
- Handshake: a request is accepted on a rising edge with `req_valid & req_ready`. `req_ready` is 1 only in IDLE and is low whenever `done` is low outside IDLE. `req_val` and `req_force` are captured at acceptance.
- FSM states: IDLE, GAP_PRE, PULSE, GAP_POST.
  - IDLE → GAP_PRE on acceptance when `req_force` = 1, or `shadow_vld` = 0, or `req_val` ≠ `shadow_q`.
  - If none of those hold, acceptance is a skip: the FSM stays in IDLE, `done` = 1 next cycle, and no pulse is issued.
  - GAP_PRE → PULSE after GAP_CYC cycles.
  - PULSE → GAP_POST after PULSE_CYC cycles.
  - GAP_POST → IDLE after GAP_CYC cycles, with `done` = 1 in the first IDLE cycle.
- Outputs are registered.
  - In PULSE: `en` = 1; `s` = captured value; `r` = ~captured value.
  - In all other states: `s` = `r` = `en` = 0.
- Shadow update: `shadow_q` ← captured value and `shadow_vld` ← 1 on entry to GAP_POST.
- Invariants, with a required assertion for each: `s & r` = 0 at all times; `(s | r)` implies `en`.
- A back-to-back request may be accepted in the `done` cycle, since `req_ready` = 1 then.

## Timing
- Reset values (asynchronous, `rst_n` = 0): state IDLE; `s` = `r` = `en` = 0; `done` = 0; `busy` = 0; `req_ready` = 1 after release; `shadow_q` = 0; `shadow_vld` = 0; `err` = 0.
- Reset mid-operation aborts the pulse immediately. The latch keeps whatever it holds, and the shadow becomes invalid.
- Pulsed write with request accepted at edge T:
  - GAP_PRE occupies cycles T+1 … T+GAP_CYC.
  - PULSE occupies the next PULSE_CYC cycles.
  - GAP_POST occupies the next GAP_CYC cycles.
  - `done` is high in cycle T + 2·GAP_CYC + PULSE_CYC + 1.
  - With defaults, `done` is high at T+9.
- Skipped write: `done` is high at T+1.
- Counters are sized as `$clog2(max(PULSE_CYC, GAP_CYC)+1)` bits. Each counter loads N−1 on state entry and decrements to 0.

## Configuration
- `SR_LATCH_DRIVER_READBACK_EN`:
  - Defined: on the last PULSE cycle, sample `q_in` and `qbar_in`. Set `err` (sticky until `rst_n`) if `q_in` ≠ captured value or `q_in` == `qbar_in`.
  - Undefined: `err` is tied to 0, and `q_in`/`qbar_in` remain as ports but are unused.

## Structure
- Package `sr_drv_pkg`:
  - state enum `sr_drv_state_t` {IDLE, GAP_PRE, PULSE, GAP_POST};
  - helper function for the counter width.
- One sub-module, `sr_drv_timer`: a loadable down-counter with a `load`/`value` input and a `zero` output. It is instantiated once and reloaded per state.
- FSM, capture register, shadow and readback check live in `sr_latch_driver`.

## Test plan
- Reset release, then `req_val` = 1 at T → cycles T+1–T+2 all low; `s` = `en` = 1 for T+3–T+6; low for T+7–T+8; `done` at T+9; `shadow_q` = 1, `shadow_vld` = 1; latch `q` = 1.
- Repeat `req_val` = 1 with `req_force` = 0 → `done` at T+1; `s`, `r`, `en` stay 0 throughout.
- Same request with `req_force` = 1 → full 9-cycle pulse sequence is reissued.
- `req_val` = 0 accepted in the `done` cycle of a prior write → `r` pulse with correct gaps; `s & r` never observed; `q` = 0.
- Assert `rst_n` = 0 during PULSE → `s`, `r`, `en` drop asynchronously; `shadow_vld` = 0; the next request always pulses.
- With `SR_LATCH_DRIVER_READBACK_EN` defined, force `q_in` = 0 during a set pulse → `err` = 1 and stays 1 until reset. Without the macro, `err` stays 0.
